// File: rtl/note_recorder_if.sv
// note_recorder_if: switch/command inputs and tone/status outputs of the note recorder
interface note_recorder_if #(
   parameter int DEPTH = 64
) ();
   logic [7:0]               sw_in;
   logic                     rec_start;
   logic                     play_start;
   logic                     stop;
   logic [7:0]               lfsr_en;
   logic                     recording;
   logic                     playing;
   logic [$clog2(DEPTH):0]   rec_len;
   logic                     done;
   modport master (
      output sw_in, rec_start, play_start, stop,
      input  lfsr_en, recording, playing, rec_len, done
   );
   modport slave (
      input  sw_in, rec_start, play_start, stop,
      output lfsr_en, recording, playing, rec_len, done
   );
endinterface

// File: rtl/note_recorder.sv
// note_recorder: records piano switch steps per beat and plays them back to the tone enables.
// Define LOOP_PLAY_EN to make playback wrap to step 0 instead of ending with done.
module note_recorder #(
   parameter int DEPTH      = 64,
   parameter int BEAT_TICKS = 6250000
) (
   input  logic           clk,
   input  logic           rst_n,
   note_recorder_if.slave bus_io
);
   localparam int              AW        = $clog2(DEPTH);
   localparam int              BW        = $clog2(BEAT_TICKS);
   localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
   localparam logic [AW:0]     LEN_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);
   localparam logic [BW-1:0]   BEAT_LAST = BW'(BEAT_TICKS - 1);
   localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);
   typedef enum logic [1:0] {IDLE, REC, PLAY} state_e;
   state_e          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW:0]     rec_len_q, rec_len_d;
   logic [7:0]      lfsr_q, lfsr_d;
   logic            done_q, done_d;
   logic            wr_en;
   logic            beat_end;
   logic [7:0]      mem [DEPTH];
   assign beat_end = beat_q == BEAT_LAST;
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_end ? '0 : beat_q + BEAT_ONE;
      addr_d    = addr_q;
      rec_len_d = rec_len_q;
      lfsr_d    = bus_io.sw_in;
      done_d    = 1'b0;
      wr_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            beat_d = '0;
            if (bus_io.rec_start) begin
               state_d   = REC;
               rec_len_d = '0;
            end else if (bus_io.play_start) begin
               if (rec_len_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = PLAY;
                  addr_d  = '0;
                  lfsr_d  = mem[0];
               end
            end
         end
         REC: begin
            if (bus_io.stop) begin
               state_d = IDLE;
               beat_d  = '0;
            end else if (beat_end) begin
               wr_en     = 1'b1;
               rec_len_d = rec_len_q + LEN_ONE;
               if (rec_len_q + LEN_ONE == FULL) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         PLAY: begin
            lfsr_d = lfsr_q;
            if (bus_io.stop) begin
               state_d = IDLE;
               beat_d  = '0;
               lfsr_d  = bus_io.sw_in;
            end else if (beat_end) begin
               if ({1'b0, addr_q} == rec_len_q - LEN_ONE) begin
`ifdef LOOP_PLAY_EN
                  addr_d  = '0;
                  lfsr_d  = mem[0];
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
                  lfsr_d  = bus_io.sw_in;
`endif
               end else begin
                  addr_d = addr_q + ADDR_ONE;
                  lfsr_d = mem[addr_q + ADDR_ONE];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         addr_q    <= '0;
         rec_len_q <= '0;
         lfsr_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         addr_q    <= addr_d;
         rec_len_q <= rec_len_d;
         lfsr_q    <= lfsr_d;
         done_q    <= done_d;
      end
   end
   // step storage is deliberately unreset; only entries below rec_len are ever read
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) mem[rec_len_q[AW-1:0]] <= bus_io.sw_in;
   end
   assign bus_io.lfsr_en   = lfsr_q;
   assign bus_io.recording = state_q == REC;
   assign bus_io.playing   = state_q == PLAY;
   assign bus_io.rec_len   = rec_len_q;
   assign bus_io.done      = done_q;
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed record/playback scenarios with a cycle-tagged scoreboard and done-pulse monitor.
module tb_note_recorder;
`ifdef LOOP_PLAY_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   typedef struct {
      int         cyc;
      string      name;
      logic [7:0] lfsr;
      logic       rec;
      logic       play;
      logic [2:0] len;
      logic       done;
   } snap_t;
   logic  clk = 1'b0;
   logic  rst_n;
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   snap_t sq[$];
   int    dq[$];
   note_recorder_if #(.DEPTH(4)) bus ();
   note_recorder #(.DEPTH(4), .BEAT_TICKS(3)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask
   function automatic void expect_at(input int c, input string n, input logic [7:0] l,
                                     input logic r, input logic p, input logic [2:0] len, input logic d);
      snap_t s;
      s.cyc = c; s.name = n; s.lfsr = l; s.rec = r; s.play = p; s.len = len; s.done = d;
      sq.push_back(s);
   endfunction
   always @(negedge clk) begin
      while (sq.size() != 0 && sq[0].cyc <= cyc) begin
         snap_t s;
         s = sq.pop_front();
         n_checks++;
         if (s.cyc != cyc ||
             {bus.lfsr_en, bus.recording, bus.playing, bus.rec_len, bus.done} !== {s.lfsr, s.rec, s.play, s.len, s.done}) begin
            n_fail++;
            $display("FAIL %s @%0d: got lfsr=%h rec=%b play=%b len=%0d done=%b, expected lfsr=%h rec=%b play=%b len=%0d done=%b",
                     s.name, cyc, bus.lfsr_en, bus.recording, bus.playing, bus.rec_len, bus.done,
                     s.lfsr, s.rec, s.play, s.len, s.done);
         end
      end
      while (dq.size() != 0 && dq[0] < cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_missing: no pulse at cycle %0d, expected one", dq.pop_front());
      end
      if (bus.done === 1'b1) begin
         n_checks++;
         if (dq.size() != 0 && dq[0] == cyc) void'(dq.pop_front());
         else begin
            n_fail++;
            $display("FAIL done_unexpected: pulse at cycle %0d, expected none", cyc);
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 1'b0;
      bus.sw_in = 8'h00; bus.rec_start = 1'b0; bus.play_start = 1'b0; bus.stop = 1'b0;
      tick();
      expect_at(cyc + 1, "reset", 8'h00, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      // full 4-step recording
      bus.sw_in = 8'h01; bus.rec_start = 1'b1;
      expect_at(cyc + 1, "rec_enter", 8'h01, 1, 0, 0, 0);
      tick();
      bus.rec_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.sw_in = 8'h01 << i;
         expect_at(cyc + 2, "rec_mid", 8'h01 << i, 1, 0, 3'(i), 0);
         expect_at(cyc + 3, "rec_step", 8'h01 << i, i != 3, 0, 3'(i + 1), i == 3);
         if (i == 3) dq.push_back(cyc + 3);
         tick(3);
      end
      expect_at(cyc + 1, "rec_full_idle", 8'h08, 0, 0, 4, 0);
      tick();
      // playback of the four steps
      bus.sw_in = 8'hFF; bus.play_start = 1'b1;
      expect_at(cyc + 1, "play_first", 8'h01, 0, 1, 4, 0);
      tick();
      bus.play_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_at(cyc + 2, "play_hold", 8'h01 << i, 0, 1, 4, 0);
         if (i < 3) expect_at(cyc + 3, "play_next", 8'h01 << (i + 1), 0, 1, 4, 0);
         else begin
            expect_at(cyc + 3, "play_end", LOOP ? 8'h01 : 8'hFF, 0, LOOP, 4, !LOOP);
            if (!LOOP) dq.push_back(cyc + 3);
         end
         tick(3);
      end
      bus.sw_in = 8'h3C; bus.stop = LOOP;
      expect_at(cyc + 1, "play_live", 8'h3C, 0, 0, 4, 0);
      tick();
      bus.stop = 1'b0;
      // two steps, then stop mid-beat
      bus.sw_in = 8'hAA; bus.rec_start = 1'b1;
      expect_at(cyc + 1, "rec2_enter", 8'hAA, 1, 0, 0, 0);
      tick();
      bus.rec_start = 1'b0;
      expect_at(cyc + 3, "rec2_s0", 8'hAA, 1, 0, 1, 0);
      tick(3);
      bus.sw_in = 8'h55;
      expect_at(cyc + 3, "rec2_s1", 8'h55, 1, 0, 2, 0);
      tick(4);
      bus.sw_in = 8'h11; bus.stop = 1'b1;
      expect_at(cyc + 1, "rec_stop", 8'h11, 0, 0, 2, 0);
      tick();
      bus.stop = 1'b0;
      bus.play_start = 1'b1;
      expect_at(cyc + 1, "play2_s0", 8'hAA, 0, 1, 2, 0);
      tick();
      bus.play_start = 1'b0;
      expect_at(cyc + 2, "play2_hold", 8'hAA, 0, 1, 2, 0);
      expect_at(cyc + 3, "play2_s1", 8'h55, 0, 1, 2, 0);
      tick(3);
      expect_at(cyc + 3, "play2_end", LOOP ? 8'hAA : 8'h11, 0, LOOP, 2, !LOOP);
      if (!LOOP) dq.push_back(cyc + 3);
      tick(3);
      bus.sw_in = 8'h22; bus.stop = LOOP;
      expect_at(cyc + 1, "play2_live", 8'h22, 0, 0, 2, 0);
      tick();
      bus.stop = 1'b0;
      // all three commands together during playback
      bus.play_start = 1'b1;
      expect_at(cyc + 1, "play3_s0", 8'hAA, 0, 1, 2, 0);
      tick(2);
      bus.stop = 1'b1; bus.rec_start = 1'b1; bus.play_start = 1'b1;
      expect_at(cyc + 1, "cmd_prio", 8'h22, 0, 0, 2, 0);
      tick();
      bus.stop = 1'b0; bus.rec_start = 1'b0; bus.play_start = 1'b0;
      expect_at(cyc + 1, "prio_after", 8'h22, 0, 0, 2, 0);
      tick();
      // reset during playback wins over a simultaneous command
      bus.play_start = 1'b1;
      expect_at(cyc + 1, "play4_s0", 8'hAA, 0, 1, 2, 0);
      tick(2);
      rst_n = 1'b0;
      expect_at(cyc + 1, "rst_play", 8'h00, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1; bus.play_start = 1'b0;
      // playback with nothing recorded
      bus.sw_in = 8'h5A; bus.play_start = 1'b1;
      expect_at(cyc + 1, "empty_play", 8'h5A, 0, 0, 0, 1);
      dq.push_back(cyc + 1);
      tick();
      bus.play_start = 1'b0; bus.sw_in = 8'hC3;
      expect_at(cyc + 1, "empty_live", 8'hC3, 0, 0, 0, 0);
      tick(4);
      while (sq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: not reached, expected at cycle %0d", sq[0].name, sq[0].cyc);
         void'(sq.pop_front());
      end
      while (dq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_missing: no pulse at cycle %0d, expected one", dq.pop_front());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
